// File: rtl/ice40_serdes_pll_sup_pkg.sv
// Shared definitions for the SERDES PLL supervisor: FSM state encoding and
// the window-count range test.
package ice40_serdes_pll_sup_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_CHECK     = 2'd2,
    ST_LOCKED    = 2'd3
  } sup_state_t;

  function automatic logic in_range(input int unsigned v,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/ice40_sync2.sv
// Two-flop synchronizer for asynchronous level/toggle inputs entering the
// supervisor's system clock domain.
module ice40_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/ice40_serdes_pll_sup.sv
// PLL supervisor: measures the divided SERDES clock via a toggle over fixed
// windows, reports monitor-OK and drives PLL RESETB on lock loss or bad rate.
module ice40_serdes_pll_sup
  import ice40_serdes_pll_sup_pkg::*;
#(
  parameter int WIN_LOG2 = 10,
  parameter int CNT_MIN  = 240,
  parameter int CNT_MAX  = 272,
  parameter int GOOD_WIN = 4,
  parameter int BAD_WIN  = 2,
  parameter int LOCK_TO  = 8,
  parameter int RST_LEN  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mon_tgl,
  input  logic              pll_lock,
  input  logic              sw_reset,
  output logic              pll_resetb,
  output logic              mon_ok,
  output logic [WIN_LOG2:0] mon_cnt,
  output logic              mon_cnt_stb
);

  localparam int CW  = WIN_LOG2 + 1;
  localparam int RW  = $clog2(RST_LEN + 1);
  localparam int GWD = $clog2(GOOD_WIN + 1);
  localparam int BWD = $clog2(BAD_WIN + 1);
  localparam int TW  = $clog2(LOCK_TO + 1);

  logic [1:0] sync_q;
  logic       tgl_s;
  logic       lock_s;
  logic       tgl_prev_reg;
  logic       tgl_edge;

  sup_state_t state_reg, state_next;
  logic [WIN_LOG2-1:0] win_reg, win_next;
  logic [CW-1:0]       ecnt_reg, ecnt_next;
  logic [GWD-1:0]      good_reg, good_next;
  logic [BWD-1:0]      bad_reg, bad_next;
  logic [TW-1:0]       to_reg, to_next;
  logic [RW-1:0]       rst_reg, rst_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic                stb_reg, stb_next;
  logic                resetb_reg;
  logic                ok_reg;

  logic          win_end;
  logic [CW-1:0] closing;
  logic          good;

  ice40_sync2 #(.WIDTH(2)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({pll_lock, mon_tgl}),
    .q     (sync_q)
  );

  assign lock_s   = sync_q[1];
  assign tgl_s    = sync_q[0];
  assign tgl_edge = tgl_s ^ tgl_prev_reg;

  // Running count including this cycle's edge, so an edge on the window-end
  // cycle lands in the closing window.
  assign win_end = &win_reg;
  assign closing = (&ecnt_reg) ? ecnt_reg : ecnt_reg + CW'(tgl_edge);
  assign good    = in_range(32'(closing), CNT_MIN, CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgl_prev_reg <= 1'b0;
      state_reg    <= ST_RESET;
      win_reg      <= '0;
      ecnt_reg     <= '0;
      good_reg     <= '0;
      bad_reg      <= '0;
      to_reg       <= '0;
      rst_reg      <= '0;
      cnt_reg      <= '0;
      stb_reg      <= 1'b0;
      resetb_reg   <= 1'b0;
      ok_reg       <= 1'b0;
    end else begin
      tgl_prev_reg <= tgl_s;
      state_reg    <= state_next;
      win_reg      <= win_next;
      ecnt_reg     <= ecnt_next;
      good_reg     <= good_next;
      bad_reg      <= bad_next;
      to_reg       <= to_next;
      rst_reg      <= rst_next;
      cnt_reg      <= cnt_next;
      stb_reg      <= stb_next;
      resetb_reg   <= (state_next != ST_RESET);
      ok_reg       <= (state_next == ST_LOCKED);
    end
  end

  always_comb begin
    state_next = state_reg;
    win_next   = win_reg;
    ecnt_next  = ecnt_reg;
    good_next  = good_reg;
    bad_next   = bad_reg;
    to_next    = to_reg;
    rst_next   = rst_reg;
    cnt_next   = cnt_reg;
    stb_next   = 1'b0;

    case (state_reg)
      ST_RESET: begin
        win_next  = '0;
        ecnt_next = '0;
        to_next   = '0;
        if (rst_reg == RW'(RST_LEN - 1)) state_next = ST_WAIT_LOCK;
        else                             rst_next   = rst_reg + RW'(1);
      end

      ST_WAIT_LOCK: begin
        win_next = win_reg + WIN_LOG2'(1);
        if (lock_s) begin
          state_next = ST_CHECK;
          win_next   = '0;
          ecnt_next  = '0;
          good_next  = '0;
        end else if (win_end) begin
          if (to_reg == TW'(LOCK_TO - 1)) state_next = ST_RESET;
          else                            to_next    = to_reg + TW'(1);
        end
      end

      ST_CHECK, ST_LOCKED: begin
        win_next  = win_reg + WIN_LOG2'(1);
        ecnt_next = win_end ? '0 : closing;
        if (!lock_s) begin
          state_next = ST_RESET;
        end else if (win_end) begin
          cnt_next = closing;
          stb_next = 1'b1;
          if (state_reg == ST_CHECK) begin
            if (!good) begin
              good_next = '0;
            end else if (good_reg == GWD'(GOOD_WIN - 1)) begin
              state_next = ST_LOCKED;
              bad_next   = '0;
            end else begin
              good_next = good_reg + GWD'(1);
            end
          end else begin
            if (good) begin
              bad_next = '0;
            end else if (bad_reg == BWD'(BAD_WIN - 1)) begin
              state_next = ST_RESET;
            end else begin
              bad_next = bad_reg + BWD'(1);
            end
          end
        end
      end

      default: state_next = ST_RESET;
    endcase

    // A software request aborts whatever window was closing this cycle.
    if (sw_reset) begin
      state_next = ST_RESET;
      cnt_next   = cnt_reg;
      stb_next   = 1'b0;
    end

    if ((state_next == ST_RESET) && ((state_reg != ST_RESET) || sw_reset))
      rst_next = '0;
  end

  assign pll_resetb  = resetb_reg;
  assign mon_ok      = ok_reg;
  assign mon_cnt     = cnt_reg;
  assign mon_cnt_stb = stb_reg;

endmodule

// File: tb/tb_ice40_serdes_pll_sup.sv
// Randomized bench for the PLL supervisor, checked every cycle against a
// cycle-count/window-sum model plus a few hand-derived timing expectations.
module tb_ice40_serdes_pll_sup;

  localparam int WL   = 6;
  localparam int WIN  = 64;
  localparam int CMIN = 14;
  localparam int CMAX = 18;
  localparam int GW   = 4;
  localparam int BW   = 2;
  localparam int LTO  = 8;
  localparam int RL   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mon_tgl = 1'b0;
  logic pll_lock = 1'b0;
  logic sw_reset = 1'b0;
  logic pll_resetb;
  logic mon_ok;
  logic [WL:0] mon_cnt;
  logic mon_cnt_stb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ice40_serdes_pll_sup #(
    .WIN_LOG2(WL), .CNT_MIN(CMIN), .CNT_MAX(CMAX), .GOOD_WIN(GW),
    .BAD_WIN(BW), .LOCK_TO(LTO), .RST_LEN(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mon_tgl(mon_tgl), .pll_lock(pll_lock),
    .sw_reset(sw_reset), .pll_resetb(pll_resetb), .mon_ok(mon_ok),
    .mon_cnt(mon_cnt), .mon_cnt_stb(mon_cnt_stb)
  );

  // Toggle source: 0 = frozen, 1 = periodic, 2 = random (p=1/4 per clk)
  int tgl_mode = 0;
  int tgl_period = 4;
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tgl_mode == 1) begin
        ph++;
        if (ph >= tgl_period) begin
          ph = 0;
          mon_tgl = ~mon_tgl;
        end
      end else if (tgl_mode == 2) begin
        if ($urandom_range(3) == 0) mon_tgl = ~mon_tgl;
      end
    end
  end

  // Reference model: inputs seen through a 3-deep sample history, windows
  // tracked as a position and running sum, phases as remaining/elapsed counts.
  typedef enum {PH_PLL_RST, PH_SEEK, PH_MEAS, PH_OK} phase_t;
  phase_t m_phase;
  int m_left, m_waited, m_pos, m_acc, m_streak, m_bstreak, m_cnt;
  bit m_stb;
  bit h_t[3];
  bit h_l[3];

  initial begin
    bit e, lk, ok_win;
    int tot;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = PH_PLL_RST; m_left = RL; m_cnt = 0; m_stb = 0;
        m_waited = 0; m_pos = 0; m_acc = 0; m_streak = 0; m_bstreak = 0;
        for (int i = 0; i < 3; i++) begin h_t[i] = 0; h_l[i] = 0; end
      end else begin
        e = h_t[1] ^ h_t[2];
        lk = h_l[1];
        m_stb = 0;
        if (sw_reset) begin
          m_phase = PH_PLL_RST; m_left = RL;
        end else begin
          case (m_phase)
            PH_PLL_RST: begin
              if (m_left == 1) begin m_phase = PH_SEEK; m_waited = 0; end
              else m_left--;
            end
            PH_SEEK: begin
              if (lk) begin
                m_phase = PH_MEAS; m_pos = 0; m_acc = 0; m_streak = 0;
              end else begin
                m_waited++;
                if (m_waited == LTO * WIN) begin m_phase = PH_PLL_RST; m_left = RL; end
              end
            end
            default: begin
              if (!lk) begin
                m_phase = PH_PLL_RST; m_left = RL;
              end else begin
                tot = m_acc + int'(e);
                if (tot > 2 * WIN - 1) tot = 2 * WIN - 1;
                if (m_pos == WIN - 1) begin
                  m_cnt = tot; m_stb = 1; m_pos = 0; m_acc = 0;
                  ok_win = (tot >= CMIN) && (tot <= CMAX);
                  if (m_phase == PH_MEAS) begin
                    m_streak = ok_win ? m_streak + 1 : 0;
                    if (m_streak == GW) begin m_phase = PH_OK; m_bstreak = 0; end
                  end else begin
                    m_bstreak = ok_win ? 0 : m_bstreak + 1;
                    if (m_bstreak == BW) begin m_phase = PH_PLL_RST; m_left = RL; end
                  end
                end else begin
                  m_acc = tot; m_pos++;
                end
              end
            end
          endcase
        end
        h_t[2] = h_t[1]; h_t[1] = h_t[0]; h_t[0] = mon_tgl;
        h_l[2] = h_l[1]; h_l[1] = h_l[0]; h_l[0] = pll_lock;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("pll_resetb", int'(pll_resetb), int'(m_phase != PH_PLL_RST));
      chk("mon_ok", int'(mon_ok), int'(m_phase == PH_OK));
      chk("mon_cnt", int'(mon_cnt), m_cnt);
      chk("mon_cnt_stb", int'(mon_cnt_stb), int'(m_stb));
      if (mon_cnt_stb)
        $display("[%0t] window mon_cnt=%0d mon_ok=%0d", $time, mon_cnt, mon_ok);
    end
  end

  // which: 0 mon_ok, 1 pll_resetb, 2 mon_cnt_stb. cyc counts negedges elapsed.
  task automatic wait_sig(input int which, input int val, input int limit,
                          input string nm, output int cyc);
    int v;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      case (which)
        0:       v = int'(mon_ok);
        1:       v = int'(pll_resetb);
        default: v = int'(mon_cnt_stb);
      endcase
      if (v == val) return;
      if (cyc >= limit) begin
        n_cmp++; n_bad++;
        $display("FAIL %s: got %0d after %0d cycles, expected %0d", nm, v, cyc, val);
        return;
      end
    end
  endtask

  task automatic pulse_sw();
    sw_reset = 1'b1;
    @(negedge clk);
    sw_reset = 1'b0;
  endtask

  initial begin
    int cyc;
    int dur;

    // 1: reset state, bring-up, nominal rate
    tgl_mode = 1; tgl_period = 4;
    repeat (3) @(negedge clk);
    chk("reset_resetb", int'(pll_resetb), 0);
    chk("reset_ok", int'(mon_ok), 0);
    chk("reset_cnt", int'(mon_cnt), 0);
    chk("reset_stb", int'(mon_cnt_stb), 0);
    rst_n = 1'b1;
    wait_sig(1, 1, 20, "bringup_resetb_high", cyc);
    chk("bringup_resetb_low_len", cyc, RL);
    repeat (6) @(negedge clk);
    pll_lock = 1'b1;
    wait_sig(2, 1, 200, "first_stb", cyc);
    chk("nominal_mon_cnt", int'(mon_cnt), 16);
    wait_sig(0, 1, 400, "nominal_lock_ok", cyc);
    chk("nominal_mon_ok", int'(mon_ok), 1);

    // 2a: one bad window then a good one keeps mon_ok
    wait_sig(2, 1, 100, "pre_bad_stb", cyc);
    tgl_period = 2;
    wait_sig(2, 1, 100, "bad_stb", cyc);
    tgl_period = 4;
    wait_sig(2, 1, 100, "good_stb", cyc);
    chk("single_bad_keeps_ok", int'(mon_ok), 1);

    // 2b: two bad windows force a PLL reset
    tgl_period = 2;
    wait_sig(0, 0, 300, "double_bad_drop", cyc);
    chk("double_bad_resetb", int'(pll_resetb), 0);
    wait_sig(1, 1, 20, "double_bad_resetb_high", cyc);
    chk("double_bad_resetb_len", cyc, RL);
    tgl_period = 4;
    wait_sig(0, 1, 500, "relock_ok", cyc);

    // 3: one-cycle lock dropout
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    wait_sig(1, 0, 10, "lockloss_resetb", cyc);
    n_cmp++;
    if (cyc + 1 > 4) begin
      n_bad++;
      $display("FAIL lockloss_latency: got %0d cycles, expected at most 4", cyc + 1);
    end
    chk("lockloss_ok", int'(mon_ok), 0);
    wait_sig(0, 1, 500, "lockloss_relock", cyc);

    // 5: software reset while locked, then again mid-RESET
    pulse_sw();
    chk("sw_resetb_low", int'(pll_resetb), 0);
    chk("sw_ok_low", int'(mon_ok), 0);
    @(negedge clk);
    pulse_sw();
    wait_sig(1, 1, 20, "sw_resetb_high", cyc);
    chk("sw_restart_len", cyc, RL);

    // 6: frozen toggle never qualifies
    tgl_mode = 0;
    repeat (4) wait_sig(2, 1, 300, "frozen_stb", cyc);
    chk("frozen_mon_cnt", int'(mon_cnt), 0);
    chk("frozen_mon_ok", int'(mon_ok), 0);

    // 4: no lock at all -> periodic reset retries
    tgl_mode = 1;
    pll_lock = 1'b0;
    wait_sig(1, 0, 20, "nolock_first_low", cyc);
    wait_sig(1, 1, 20, "nolock_first_high", cyc);
    wait_sig(1, 0, LTO * WIN + 20, "nolock_retry_low", cyc);
    chk("nolock_wait_len", cyc, LTO * WIN);
    wait_sig(1, 1, 20, "nolock_retry_high", cyc);
    chk("nolock_reset_len", cyc, RL);
    chk("nolock_ok", int'(mon_ok), 0);

    // Randomized phase
    for (int it = 0; it < 30; it++) begin
      dur = $urandom_range(9);
      tgl_mode = (dur == 0) ? 0 : (dur < 4) ? 1 : 2;
      tgl_period = $urandom_range(1, 6);
      if ($urandom_range(2) == 0) tgl_period = 4;
      pll_lock = ($urandom_range(9) != 0);
      dur = $urandom_range(100, 800);
      for (int c = 0; c < dur; c++) begin
        @(negedge clk);
        sw_reset = ($urandom_range(499) == 0);
        if ($urandom_range(999) == 0) pll_lock = ~pll_lock;
      end
      sw_reset = 1'b0;
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
